// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master (AW, W, B) among NUM_REQ requesters.
// One command per grant; W beats pass through from the granted requester with a local w_last.
module axi_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_BITS-1:0]    req_len,
  input  logic [NUM_REQ*SIZE_BITS-1:0]   req_size,
  input  logic [NUM_REQ*2-1:0]           req_burst,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]             req_wvalid,
  output logic [NUM_REQ-1:0]             req_wready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [1:0]                     req_resp,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [ADDR_BITS-1:0]           aw_addr,
  output logic [LEN_BITS-1:0]            aw_len,
  output logic [SIZE_BITS-1:0]           aw_size,
  output logic [1:0]                     aw_burst,
  output logic [3:0]                     aw_cache,
  output logic                           aw_valid,
  input  logic                           aw_ready,
  output logic [DATA_BITS-1:0]           w_data,
  output logic [DATA_BITS/8-1:0]         w_strb,
  output logic                           w_last,
  output logic                           w_valid,
  input  logic                           w_ready,
  input  logic                           b_valid,
  input  logic [1:0]                     b_resp,
  output logic                           b_ready
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t                 state_reg, state_next;
  logic [GW-1:0]          grant_reg, grant_next;
  logic [GW-1:0]          last_grant_reg, last_grant_next;
  logic [ADDR_BITS-1:0]   aw_addr_reg, aw_addr_next;
  logic [LEN_BITS-1:0]    aw_len_reg, aw_len_next;
  logic [SIZE_BITS-1:0]   aw_size_reg, aw_size_next;
  logic [1:0]             aw_burst_reg, aw_burst_next;
  logic [LEN_BITS-1:0]    beat_reg, beat_next;
  logic [NUM_REQ-1:0]     ack_reg, ack_next;
  logic [NUM_REQ-1:0]     done_reg, done_next;
  logic [1:0]             resp_reg, resp_next;

  logic [ADDR_BITS-1:0]   addr_arr  [NUM_REQ];
  logic [LEN_BITS-1:0]    len_arr   [NUM_REQ];
  logic [SIZE_BITS-1:0]   size_arr  [NUM_REQ];
  logic [1:0]             burst_arr [NUM_REQ];
  logic [DATA_BITS-1:0]   wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign len_arr[gi]   = req_len[gi*LEN_BITS +: LEN_BITS];
      assign size_arr[gi]  = req_size[gi*SIZE_BITS +: SIZE_BITS];
      assign burst_arr[gi] = req_burst[gi*2 +: 2];
      assign wdata_arr[gi] = req_wdata[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[GW-1:0];
  endfunction

  // Search starts one past the last completed grant, so the previous winner is checked last.
  logic          rr_found;
  logic [GW-1:0] rr_winner;
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!rr_found && req_valid[wrap_idx(last_grant_reg, i)]) begin
        rr_found  = 1'b1;
        rr_winner = wrap_idx(last_grant_reg, i);
      end
    end
  end

  logic in_data;
  logic w_hs;
  assign in_data = (state_reg == ST_DATA);
  assign w_valid = in_data & req_wvalid[grant_reg];
  assign w_data  = in_data ? wdata_arr[grant_reg] : '0;
  assign w_strb  = in_data ? '1 : '0;
  assign w_last  = in_data && (beat_reg == aw_len_reg);
  assign w_hs    = w_valid & w_ready;

  always_comb begin
    req_wready = '0;
    if (in_data) req_wready[grant_reg] = w_ready;
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    aw_addr_next    = aw_addr_reg;
    aw_len_next     = aw_len_reg;
    aw_size_next    = aw_size_reg;
    aw_burst_next   = aw_burst_reg;
    beat_next       = beat_reg;
    ack_next        = '0;
    done_next       = '0;
    resp_next       = resp_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rr_found) begin
          grant_next    = rr_winner;
          aw_addr_next  = addr_arr[rr_winner];
          aw_len_next   = len_arr[rr_winner];
          aw_size_next  = size_arr[rr_winner];
          aw_burst_next = burst_arr[rr_winner];
          beat_next     = '0;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_ready) begin
          ack_next[grant_reg] = 1'b1;
          state_next          = ST_DATA;
        end
      end
      ST_DATA: begin
        // The counter stops at aw_len, so a maximum-length burst never wraps.
        if (w_hs) begin
          if (w_last) state_next = ST_RESP;
          else        beat_next  = beat_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (b_valid) begin
          done_next[grant_reg] = 1'b1;
          resp_next            = b_resp;
          last_grant_next      = grant_reg;
          state_next           = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      aw_addr_reg    <= '0;
      aw_len_reg     <= '0;
      aw_size_reg    <= '0;
      aw_burst_reg   <= '0;
      beat_reg       <= '0;
      ack_reg        <= '0;
      done_reg       <= '0;
      resp_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      aw_addr_reg    <= aw_addr_next;
      aw_len_reg     <= aw_len_next;
      aw_size_reg    <= aw_size_next;
      aw_burst_reg   <= aw_burst_next;
      beat_reg       <= beat_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      resp_reg       <= resp_next;
    end
  end

  assign aw_addr  = aw_addr_reg;
  assign aw_len   = aw_len_reg;
  assign aw_size  = aw_size_reg;
  assign aw_burst = aw_burst_reg;
  assign aw_cache = 4'b0011;
  assign aw_valid = (state_reg == ST_ADDR);
  assign b_ready  = (state_reg == ST_RESP);
  assign busy     = (state_reg != ST_IDLE);
  assign grant_id = grant_reg;
  assign req_ack  = ack_reg;
  assign req_done = done_reg;
  assign req_resp = resp_reg;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: a transaction table applied in a loop plus
// hand-written latency and mid-burst reset sequences.
module tb_axi_wr_arbiter;

  localparam int NR = 4;

  logic            aclk;
  logic            areset;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR*8-1:0] req_len;
  logic [NR*3-1:0] req_size;
  logic [NR*2-1:0] req_burst;
  logic [NR-1:0]   req_ack;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]   req_wvalid;
  logic [NR-1:0]   req_wready;
  logic [NR-1:0]   req_done;
  logic [1:0]      req_resp;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic [3:0]      aw_cache;
  logic            aw_valid;
  logic            aw_ready;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;
  logic            b_valid;
  logic [1:0]      b_resp;
  logic            b_ready;

  axi_wr_arbiter #(.NUM_REQ(NR), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(8), .SIZE_BITS(3)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_burst(req_burst), .req_ack(req_ack), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
    .req_wready(req_wready), .req_done(req_done), .req_resp(req_resp), .grant_id(grant_id),
    .busy(busy), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_cache(aw_cache), .aw_valid(aw_valid), .aw_ready(aw_ready), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        do_reset;
    logic [3:0]  mask;
    logic [7:0]  len;
    logic [1:0]  exp_id;
    logic [31:0] exp_addr;
    logic [1:0]  bresp;
    logic [3:0]  aw_stall;
    logic        w_toggle;
    logic        early_b;
  } txn_t;

  logic [31:0] cfg_addr [NR];

  function automatic logic [31:0] pat(input int i);
    return 32'hDA7A_0000 | (i * 32'h1111);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_len(input logic [7:0] len);
    for (int i = 0; i < NR; i++) req_len[i*8 +: 8] = len;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_aw_valid"}, aw_valid, 0);
    chk({tag, "_aw_addr"}, aw_addr, 0);
    chk({tag, "_aw_len"}, aw_len, 0);
    chk({tag, "_aw_size"}, aw_size, 0);
    chk({tag, "_aw_burst"}, aw_burst, 0);
    chk({tag, "_b_ready"}, b_ready, 0);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_req_resp"}, req_resp, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_w_last"}, w_last, 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_w_strb"}, w_strb, 0);
    chk({tag, "_req_wready"}, req_wready, 0);
  endtask

  task automatic run_txn(input txn_t t);
    int cyc;
    int beats;
    logic [3:0] onehot;
    onehot = 4'(1 << t.exp_id);
    cyc = 0;
    while (!aw_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!aw_valid) begin
      chk("aw_valid_timeout", aw_valid, 1);
      return;
    end
    chk("grant_id", grant_id, t.exp_id);
    chk("aw_addr", aw_addr, t.exp_addr);
    chk("aw_len", aw_len, t.len);
    chk("aw_size", aw_size, 3'd2);
    chk("aw_burst", aw_burst, 2'b01);
    chk("aw_cache", aw_cache, 4'b0011);
    chk("busy_addr", busy, 1);
    for (int s = 0; s < int'(t.aw_stall); s++) begin
      tick();
      chk("aw_hold_valid", aw_valid, 1);
      chk("aw_hold_addr", aw_addr, t.exp_addr);
      chk("aw_hold_len", aw_len, t.len);
      chk("aw_hold_ack", req_ack, 0);
    end
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    chk("req_ack", req_ack, onehot);
    chk("aw_valid_clr", aw_valid, 0);

    beats = 0;
    cyc = 0;
    if (t.early_b) begin
      b_valid = 1'b1;
      b_resp  = 2'b11;
    end
    while (beats <= int'(t.len) && cyc < 600) begin
      w_ready = t.w_toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      chk("b_ready_in_data", b_ready, 0);
      if (w_valid && w_ready) begin
        chk("w_last", w_last, (beats == int'(t.len)));
        chk("w_data", w_data, pat(int'(t.exp_id)));
        chk("req_wready", req_wready, onehot);
        beats++;
      end
      tick();
      if (cyc == 0) chk("req_ack_pulse", req_ack, 0);
      cyc++;
    end
    w_ready = 1'b0;
    chk("beat_count", beats, int'(t.len) + 1);
    if (t.early_b) chk("early_b_no_done", req_done, 0);
    chk("b_ready_resp", b_ready, 1);
    chk("w_valid_after_last", w_valid, 0);
    b_valid = 1'b1;
    b_resp  = t.bresp;
    tick();
    b_valid = 1'b0;
    b_resp  = 2'b00;
    chk("req_done", req_done, onehot);
    chk("req_resp", req_resp, t.bresp);
    chk("busy_after_b", busy, 0);
    chk("b_ready_clr", b_ready, 0);
    $display("txn: mask=%b grant=%0d addr=0x%08h len=%0d beats=%0d resp=%0d",
             t.mask, grant_id, aw_addr, aw_len, beats, req_resp);
  endtask

  txn_t tbl [11];
  txn_t extra;

  initial begin
    // do_reset, mask, len, exp_id, exp_addr, bresp, aw_stall, w_toggle, early_b
    tbl[0]  = '{1'b1, 4'b1111, 8'd1,   2'd0, 32'h0000_1000, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 8'd1,   2'd1, 32'h0000_2000, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 8'd1,   2'd2, 32'h0000_0100, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 8'd1,   2'd3, 32'h0000_4000, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 8'd1,   2'd0, 32'h0000_1000, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0100, 8'd3,   2'd2, 32'h0000_0100, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0011, 8'd7,   2'd0, 32'h0000_1000, 2'b00, 4'd5, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0011, 8'd2,   2'd1, 32'h0000_2000, 2'b10, 4'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'b1001, 8'd0,   2'd3, 32'h0000_4000, 2'b00, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'b1000, 8'd255, 2'd3, 32'h0000_4000, 2'b00, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b1111, 8'd0,   2'd0, 32'h0000_1000, 2'b11, 4'd0, 1'b0, 1'b0};

    cfg_addr[0] = 32'h0000_1000;
    cfg_addr[1] = 32'h0000_2000;
    cfg_addr[2] = 32'h0000_0100;
    cfg_addr[3] = 32'h0000_4000;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*32 +: 32]  = cfg_addr[i];
      req_size[i*3 +: 3]    = 3'd2;
      req_burst[i*2 +: 2]   = 2'b01;
      req_wdata[i*32 +: 32] = pat(i);
    end
    req_len    = '0;
    req_valid  = '0;
    req_wvalid = '1;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_resp     = 2'b00;
    areset     = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    chk_reset_state("rst");

    for (int k = 0; k < 11; k++) begin
      req_valid = tbl[k].mask;
      set_len(tbl[k].len);
      if (tbl[k].do_reset) begin
        areset = 1'b1;
        tick();
        areset = 1'b0;
      end
      run_txn(tbl[k]);
    end

    // Single beat with every ready high: exact cycle-by-cycle latency, early b_valid ignored.
    req_valid = 4'b0001;
    set_len(8'd0);
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    b_valid  = 1'b1;
    b_resp   = 2'b00;
    tick();
    req_valid = '0;
    chk("lat_aw_valid", aw_valid, 1);
    chk("lat_grant", grant_id, 0);
    chk("lat_busy", busy, 1);
    chk("lat_w_valid_addr", w_valid, 0);
    tick();
    chk("lat_ack", req_ack, 4'b0001);
    chk("lat_aw_clr", aw_valid, 0);
    chk("lat_w_valid", w_valid, 1);
    chk("lat_w_last", w_last, 1);
    chk("lat_w_strb", w_strb, 4'hF);
    chk("lat_b_ready_data", b_ready, 0);
    tick();
    chk("lat_b_ready", b_ready, 1);
    chk("lat_w_valid_resp", w_valid, 0);
    chk("lat_no_early_done", req_done, 0);
    tick();
    chk("lat_done", req_done, 4'b0001);
    chk("lat_idle", busy, 0);
    tick();
    chk("lat_done_pulse", req_done, 0);
    chk("lat_no_regrant", busy, 0);
    $display("txn: latency single-beat grant=0 done");
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;

    // Reset after two of four beats: everything returns to reset values, no done pulse.
    req_valid = 4'b0100;
    set_len(8'd3);
    aw_ready = 1'b1;
    tick();
    chk("mid_grant", grant_id, 2);
    chk("mid_aw_valid", aw_valid, 1);
    tick();
    aw_ready  = 1'b0;
    req_valid = '0;
    w_ready   = 1'b1;
    tick();
    tick();
    w_ready = 1'b0;
    #1;
    chk("mid_in_data", w_valid, 1);
    chk("mid_w_last_early", w_last, 0);
    areset = 1'b1;
    tick();
    chk_reset_state("mid_rst");
    areset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_done", req_done, 0);
      chk("mid_idle", busy, 0);
    end
    $display("txn: reset mid-burst grant=2 abandoned");

    extra = '{1'b0, 4'b1111, 8'd1, 2'd0, 32'h0000_1000, 2'b00, 4'd0, 1'b0, 1'b0};
    req_valid = extra.mask;
    set_len(extra.len);
    run_txn(extra);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
